boolean_3: RTL and testbench
============================

Name: boolean_3

Overview:
- 3-input Boolean function unit: output y = f(a,b,c), with f defined by an 8-entry truth-table parameter.
- Default f is a 2:1 mux form: y = (a AND b) OR (NOT a AND c).
- Provides a combinational result and an optionally registered result.
- Tracks coverage of all 8 input combinations seen on clock edges, so the block doubles as a self-checking leaf in logic-exercise benches.

Parameters:
- TRUTH_TABLE, 8'hCA, output value for each input index {a,b,c}; bit i = y for index i. Default yields minterms 1, 3, 6, 7.
- REG_OUT, 1, 1 = y registered (one-cycle latency); 0 = y equals y_comb.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- a  input  1  function input, MSB of index
- b  input  1  function input, middle bit of index
- c  input  1  function input, LSB of index
- y  output  1  function result (registered or combinational per REG_OUT)
- y_comb  output  1  combinational function result, always zero-latency
- seen  output  8  sticky coverage: bit i set once index i = {a,b,c} has been sampled
- all_seen  output  1  high when all 8 seen bits are set

Behaviour:
- Index idx = {a,b,c}, 3 bits, a is MSB.
- y_comb = TRUTH_TABLE[idx], purely combinational, no clock dependence.
- Default truth table: 000->0, 001->1, 010->0, 011->1, 100->0, 101->0, 110->1, 111->1.

y output:
- REG_OUT=1:
  - y register loads y_comb on each rising clk edge.
  - Latency is exactly 1 cycle.
  - Reset value of y is 0.
- REG_OUT=0:
  - y = y_comb continuously.
  - rst has no effect on y.

Coverage:
- On each rising clk edge with rst low: seen[idx] <= 1. All other bits hold.
- Bits never clear except by reset. Re-applying an already-seen index causes no change.
- all_seen = AND of seen[7:0], combinational from the register.

Reset:
- rst high asynchronously forces seen = 8'h00 and y = 0 (REG_OUT=1), regardless of clk.
- Held while rst is high.
- First capture occurs on the first rising edge after rst deasserts.
- Reset asserted mid-sweep discards all prior coverage.
- y_comb is unaffected by reset.

Input changes:
- Input changes between clock edges affect y_comb immediately.
- Such changes affect y and seen only at the next edge.
- No hazard filtering.

X/Z handling:
- X/Z on inputs is not masked.
- Behaviour under X inputs is don't-care and need not be verified.

Test Plan:
- Exhaustive combinational sweep: apply 000..111 in ascending order at 10 ns steps. Check y_comb = 0,1,0,1,0,0,1,1 respectively, settled within each step.
- Registered latency (REG_OUT=1): drive a=1,b=1,c=0 before edge N. Check y=1 after edge N, and y=0 after edge N+1 once inputs change to 100.
- Reset: assert rst asynchronously between edges with seen nonzero and y=1. Check seen=8'h00, y=0, all_seen=0 immediately, without waiting for clk. y_comb still tracks inputs.
- Coverage: after reset, sample indices 0..7, one per clock. Check seen grows 01,03,07,0F,1F,3F,7F,FF, and all_seen rises after the 8th edge. Repeating index 3 changes nothing.
- Custom table: TRUTH_TABLE=8'h96 (3-input XOR). Sweep all 8 indices and check y_comb = a^b^c.
- REG_OUT=0: check y equals y_comb at all times, including while rst is high.

Source files
------------

// File: rtl/boolean_3.sv
// 3-input truth-table function unit with optional output register
// and sticky coverage of every input index sampled on a clock edge.
module boolean_3 #(
  parameter logic [7:0] TRUTH_TABLE = 8'hCA,
  parameter bit         REG_OUT     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  output logic       y,
  output logic       y_comb,
  output logic [7:0] seen,
  output logic       all_seen
);

  logic [2:0] idx;
  logic [7:0] seen_d;
  logic [7:0] seen_q;

  assign idx    = {a, b, c};
  assign y_comb = TRUTH_TABLE[idx];

  always_comb begin
    seen_d      = seen_q;
    seen_d[idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_q <= 8'h00;
    end else begin
      seen_q <= seen_d;
    end
  end

  assign seen     = seen_q;
  assign all_seen = &seen_q;

  generate
    if (REG_OUT) begin : g_reg
      logic y_d;
      logic y_q;

      always_comb begin
        y_d = y_comb;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          y_q <= 1'b0;
        end else begin
          y_q <= y_d;
        end
      end

      assign y = y_q;
    end else begin : g_comb
      // Pure pass-through: reset deliberately has no effect here
      assign y = y_comb;
    end
  endgenerate

endmodule

// File: tb/tb_boolean_3.sv
// Directed bench for boolean_3: default mux table, XOR table,
// and the unregistered variant driven from shared inputs.
module tb_boolean_3;

  logic       clk;
  logic       rst;
  logic       a;
  logic       b;
  logic       c;

  logic       y_d;
  logic       yc_d;
  logic [7:0] seen_d;
  logic       all_d;

  logic       y_x;
  logic       yc_x;
  logic [7:0] seen_x;
  logic       all_x;

  logic       y_c;
  logic       yc_c;
  logic [7:0] seen_c;
  logic       all_c;

  boolean_3 u_def (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c),
    .y(y_d), .y_comb(yc_d), .seen(seen_d), .all_seen(all_d)
  );

  boolean_3 #(.TRUTH_TABLE(8'h96), .REG_OUT(1'b1)) u_xor (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c),
    .y(y_x), .y_comb(yc_x), .seen(seen_x), .all_seen(all_x)
  );

  boolean_3 #(.REG_OUT(1'b0)) u_comb (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c),
    .y(y_c), .y_comb(yc_c), .seen(seen_c), .all_seen(all_c)
  );

  typedef struct {
    logic [2:0] idx;
    logic       y_mux;
    logic       y_xor;
    logic [7:0] seen_exp;
  } vec_t;

  vec_t vecs[8];
  int   total;
  int   passed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v);
    {a, b, c} = v;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    vecs[0] = '{3'd0, 1'b0, 1'b0, 8'h01};
    vecs[1] = '{3'd1, 1'b1, 1'b1, 8'h03};
    vecs[2] = '{3'd2, 1'b0, 1'b1, 8'h07};
    vecs[3] = '{3'd3, 1'b1, 1'b0, 8'h0F};
    vecs[4] = '{3'd4, 1'b0, 1'b1, 8'h1F};
    vecs[5] = '{3'd5, 1'b0, 1'b0, 8'h3F};
    vecs[6] = '{3'd6, 1'b1, 1'b0, 8'h7F};
    vecs[7] = '{3'd7, 1'b1, 1'b1, 8'hFF};

    rst = 1'b1;
    drive(3'd0);
    #1;
    chk("rst_seen", seen_d, 8'h00);
    chk("rst_y", {7'd0, y_d}, 8'h00);
    chk("rst_all", {7'd0, all_d}, 8'h00);

    // Combinational sweep with reset held
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].idx);
      #1;
      chk($sformatf("ycomb_mux_%0d", i), {7'd0, yc_d},
          {7'd0, vecs[i].y_mux});
      chk($sformatf("ycomb_xor_%0d", i), {7'd0, yc_x},
          {7'd0, vecs[i].y_xor});
      chk($sformatf("ycomb0_y_%0d", i), {7'd0, y_c},
          {7'd0, vecs[i].y_mux});
      chk($sformatf("rst_hold_y_%0d", i), {7'd0, y_d}, 8'h00);
      #9;
    end
    chk("rst_hold_seen", seen_d, 8'h00);

    // Coverage sweep, one index per clock
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].idx);
      @(negedge clk);
      chk($sformatf("cov_seen_%0d", i), seen_d, vecs[i].seen_exp);
      chk($sformatf("cov_all_%0d", i), {7'd0, all_d},
          {7'd0, (i == 7) ? 1'b1 : 1'b0});
      chk($sformatf("reg_y_mux_%0d", i), {7'd0, y_d},
          {7'd0, vecs[i].y_mux});
      chk($sformatf("reg_y_xor_%0d", i), {7'd0, y_x},
          {7'd0, vecs[i].y_xor});
      chk($sformatf("comb_y_%0d", i), {7'd0, y_c},
          {7'd0, vecs[i].y_mux});
    end
    drive(3'd3);
    @(negedge clk);
    chk("cov_repeat", seen_d, 8'hFF);
    chk("cov_repeat_all", {7'd0, all_d}, 8'h01);

    // Registered latency
    drive(3'd6);
    @(posedge clk);
    #1;
    chk("lat_edge_n", {7'd0, y_d}, 8'h01);
    drive(3'd4);
    #1;
    chk("lat_ycomb_now", {7'd0, yc_d}, 8'h00);
    chk("lat_hold", {7'd0, y_d}, 8'h01);
    @(posedge clk);
    #1;
    chk("lat_edge_n1", {7'd0, y_d}, 8'h00);

    // Asynchronous reset mid-run
    drive(3'd6);
    @(posedge clk);
    #2;
    chk("pre_rst_y", {7'd0, y_d}, 8'h01);
    rst = 1'b1;
    #1;
    chk("arst_seen", seen_d, 8'h00);
    chk("arst_y", {7'd0, y_d}, 8'h00);
    chk("arst_all", {7'd0, all_d}, 8'h00);
    chk("arst_ycomb", {7'd0, yc_d}, 8'h01);
    chk("arst_comb_y", {7'd0, y_c}, 8'h01);
    drive(3'd5);
    #1;
    chk("arst_ycomb_trk", {7'd0, yc_d}, 8'h00);
    chk("arst_comb_y_trk", {7'd0, y_c}, 8'h00);
    @(negedge clk);
    chk("arst_held", seen_d, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    chk("first_capture", seen_d, 8'h20);
    chk("first_capture_x", seen_x, 8'h20);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
